fp_norm_round: RTL
==================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 Parameter RNE, default 1, rounding mode: 1 = round-to-nearest-even, 0 = truncate.
REQ-002 clk_i  input  1  sole clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 valid_i  input  1  raw sum on in_* valid.
REQ-005 ready_o  output  1  block accepts raw sum this cycle.
REQ-006 in_sign_i  input  1  result sign from fp_add.
REQ-007 in_exp_i  input  10  signed biased exponent of hidden-bit position (bit 26).
REQ-008 in_mant_i  input  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 in_nan_i  input  1  result is NaN, overrides mantissa.
REQ-010 in_inf_i  input  1  result is infinity, overrides mantissa.
REQ-011 valid_o  output  1  out_o valid.
REQ-012 ready_i  input  1  downstream accepts out_o.
REQ-013 out_o  output  32  float_t result.

Function
REQ-014 Two register stages; latency exactly 2 cycles from accepted input to valid_o with ready_i held high; one result per cycle throughput.
REQ-015 s2_adv = !s2_valid | ready_i; s1_adv = !s1_valid | s2_adv; ready_o = s1_adv (combinational from ready_i).
REQ-016 Transfer occurs only when valid and ready are both high; out_o and valid_o hold stable while valid_o & !ready_i.
REQ-017 Stage 1, mant[27]=1: shift right 1, exp+1, shifted-out bit ORed into sticky.
REQ-018 Stage 1, mant[27]=0, mant!=0: shift left by leading-zero count below bit 26, exp minus count; zeros fill from right.
REQ-019 Stage 1, mant==0 and no special: result +/-0 with in_sign_i.
REQ-020 Stage 2, RNE=1: increment fraction when G & (R | S | LSB); RNE=0: discard G/R/S.
REQ-021 Rounding carry out of fraction: fraction 0, exp+1.
REQ-022 Final exp >= 255: signed infinity (exp 255, fraction 0).
REQ-023 Final exp <= 0: signed zero (flush-to-zero, no subnormal outputs).
REQ-024 in_nan_i: out 0x7FC00000; else in_inf_i: signed infinity; NaN takes priority.
REQ-025 Simultaneous accept at stage 1 and drain at stage 2 in the same cycle shall lose no data.

Reset
REQ-026 rst_ni low: both stage valids 0, valid_o 0, out_o 0, ready_o 1, immediately and asynchronously.
REQ-027 Reset mid-operation discards in-flight results; first post-reset output comes only from inputs accepted after release.

Configuration
REQ-028 FP_NORM_FLAGS_EN defined: extra output flags_o [2:0] {overflow, underflow, inexact}, aligned with out_o, reset 0.
REQ-029 inexact = any of G/R/S set or flush/overflow occurred; overflow per REQ-022; underflow per REQ-023 with nonzero mantissa.
REQ-030 FP_NORM_FLAGS_EN undefined: port absent, no flag logic.

Structure
REQ-031 float_pkg holds float_t, raw_sum_t {sign, exp, mant}, BIAS=127, EXP_MAX=255, RAW_MANT_W=28, QNAN=0x7FC00000.
REQ-032 Sub-module fp_lzc: combinational 27-bit leading-zero count, instantiated in stage 1.

Verification
REQ-033 sign 0, exp 127, mant 0x8000000 (1.0+1.0) -> out 0x40000000 after 2 cycles.
REQ-034 sign 0, exp 127, mant 0x0000008 (cancellation) -> out 0x34000000.
REQ-035 RNE=1: mant 0x4000004 exp 127 -> 0x3F800000; mant 0x400000C exp 127 -> 0x3F800002.
REQ-036 mant 0x7FFFFFC exp 127 -> 0x40000000; same mant exp 254 -> 0x7F800000 (overflow flag set if FP_NORM_FLAGS_EN).
REQ-037 Four back-to-back inputs, ready_i low 3 cycles -> ready_o low once both stages full, all four results in order, none lost or duplicated.
REQ-038 rst_ni pulsed low with two results in flight -> valid_o 0 same cycle, no stale result after release.

Source files
------------

// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared types and constants for the floating-point normalise/round slice.
//   float_t    : IEEE-754 single-precision word {sign, exp[7:0], frac[22:0]}
//   raw_sum_t  : unnormalised adder result {sign, exp[9:0] signed, mant[27:0]}
//   norm_t     : stage-1 result, hidden bit at mant[26], G/R/S at mant[2:0]
// -----------------------------------------------------------------------------
package float_pkg;

  localparam int BIAS       = 127;
  localparam int EXP_MAX    = 255;
  localparam int RAW_MANT_W = 28;
  localparam int NORM_EXP_W = 12;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  typedef struct packed {
    logic                  sign;
    logic [9:0]            exp;
    logic [RAW_MANT_W-1:0] mant;
  } raw_sum_t;

  // Exponent is widened so that +1 / -27 adjustments on a 10-bit signed
  // input can never wrap before the range checks in stage 2.
  typedef struct packed {
    logic                  sign;
    logic                  nan;
    logic                  inf;
    logic                  zero;
    logic [NORM_EXP_W-1:0] exp;
    logic [26:0]           mant;
  } norm_t;

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational 27-bit leading-zero counter.
//   value : input word, bit 26 is the most significant position
//   count : number of zeros above the highest set bit (27 when value == 0)
// -----------------------------------------------------------------------------
module fp_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the last (highest) set bit found wins.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// -----------------------------------------------------------------------------
// fp_norm_round
// Two-stage normalise-and-round back end for a single-precision adder.
// Stage 1 normalises the raw sum (carry shift-right or LZC shift-left),
// stage 2 rounds (RNE or truncate) and packs, handling overflow to
// infinity, flush-to-zero, NaN and infinity. Valid/ready on both sides.
//
// Parameters:
//   RNE       : 1 = round-to-nearest-even, 0 = truncate
// Optional build macro:
//   FP_NORM_FLAGS_EN : adds flags_o {overflow, underflow, inexact}
// Ports:
//   clk_i, rst_ni            : clock, async active-low reset
//   valid_i / ready_o        : input handshake
//   in_sign_i, in_exp_i,
//   in_mant_i, in_nan_i,
//   in_inf_i                 : raw sum from the adder
//   valid_o / ready_i        : output handshake
//   out_o                    : packed float_t result
//   flags_o                  : exception flags (FP_NORM_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fp_norm_round
  import float_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  in_sign_i,
  input  logic [9:0]            in_exp_i,
  input  logic [RAW_MANT_W-1:0] in_mant_i,
  input  logic                  in_nan_i,
  input  logic                  in_inf_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output float_t                out_o
`ifdef FP_NORM_FLAGS_EN
  ,
  output logic [2:0]            flags_o
`endif
);

  localparam logic signed [NORM_EXP_W-1:0] EXP_LIMIT = NORM_EXP_W'(EXP_MAX);

  raw_sum_t              raw;
  logic [4:0]            lz;
  logic [NORM_EXP_W-1:0] exp_ext;
  norm_t                 norm;
  norm_t                 s1;
  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  s2_adv;

  logic [22:0]           frac;
  logic                  guard;
  logic                  round_bit;
  logic                  sticky;
  logic                  round_up;
  logic [23:0]           frac_inc;
  logic [22:0]           frac_fin;
  logic [NORM_EXP_W-1:0] exp_fin;
  float_t                result;
`ifdef FP_NORM_FLAGS_EN
  logic [2:0]            flags_next;
`endif

  // A stage may load when it is empty or its contents leave this cycle,
  // so a full pipe keeps streaming one result per cycle.
  assign s2_adv  = !s2_valid || ready_i;
  assign s1_adv  = !s1_valid || s2_adv;
  assign ready_o = s1_adv;
  assign valid_o = s2_valid;

  assign raw     = '{sign: in_sign_i, exp: in_exp_i, mant: in_mant_i};
  assign exp_ext = {{(NORM_EXP_W-10){raw.exp[9]}}, raw.exp};

  fp_lzc u_lzc (
    .value (raw.mant[26:0]),
    .count (lz)
  );

  // Stage 1 normalisation: bring the leading one to bit 26.
  // The carry case keeps the dropped bit alive in sticky.
  always_comb begin
    norm      = '0;
    norm.sign = raw.sign;
    norm.nan  = in_nan_i;
    norm.inf  = in_inf_i;
    norm.exp  = exp_ext;
    if (raw.mant[27]) begin
      norm.mant = {raw.mant[27:2], raw.mant[1] | raw.mant[0]};
      norm.exp  = exp_ext + NORM_EXP_W'(1);
    end else if (raw.mant[26:0] != 27'd0) begin
      norm.mant = raw.mant[26:0] << lz;
      norm.exp  = exp_ext - NORM_EXP_W'(lz);
    end else begin
      norm.zero = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_adv) begin
      s1_valid <= valid_i;
      if (valid_i) s1 <= norm;
    end
  end

  // Stage 2 rounding and packing. A rounding carry out of the fraction
  // leaves 1.000... so the fraction clears and the exponent bumps.
  always_comb begin
    frac      = s1.mant[25:3];
    guard     = s1.mant[2];
    round_bit = s1.mant[1];
    sticky    = s1.mant[0];
    round_up  = RNE && guard && (round_bit || sticky || frac[0]);
    frac_inc  = {1'b0, frac} + 24'd1;
    frac_fin  = frac;
    exp_fin   = s1.exp;
    if (round_up) begin
      if (frac_inc[23]) begin
        frac_fin = '0;
        exp_fin  = s1.exp + NORM_EXP_W'(1);
      end else begin
        frac_fin = frac_inc[22:0];
      end
    end

`ifdef FP_NORM_FLAGS_EN
    flags_next = 3'b000;
`endif
    if (s1.nan) begin
      result = QNAN;
    end else if (s1.inf) begin
      result = '{sign: s1.sign, exp: 8'hFF, frac: 23'd0};
    end else if (s1.zero) begin
      result = '{sign: s1.sign, exp: 8'h00, frac: 23'd0};
    end else if ($signed(exp_fin) >= EXP_LIMIT) begin
      result = '{sign: s1.sign, exp: 8'hFF, frac: 23'd0};
`ifdef FP_NORM_FLAGS_EN
      flags_next = 3'b101;
`endif
    end else if ($signed(exp_fin) <= $signed(NORM_EXP_W'(0))) begin
      result = '{sign: s1.sign, exp: 8'h00, frac: 23'd0};
`ifdef FP_NORM_FLAGS_EN
      flags_next = 3'b011;
`endif
    end else begin
      result = '{sign: s1.sign, exp: exp_fin[7:0], frac: frac_fin};
`ifdef FP_NORM_FLAGS_EN
      flags_next = {2'b00, guard | round_bit | sticky};
`endif
    end
  end

  // Output register only changes when the stage advances, so a stalled
  // result stays stable until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      out_o    <= '0;
`ifdef FP_NORM_FLAGS_EN
      flags_o  <= 3'b000;
`endif
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_o   <= result;
`ifdef FP_NORM_FLAGS_EN
        flags_o <= flags_next;
`endif
      end
    end
  end

endmodule
